// File: rtl/kth_pmod_gpio.sv
// Purpose: APB-programmable 16-pin PMOD GPIO with synchronised inputs, edge events and a level IRQ.
// Latency: register writes visible on pins at the commit edge; pin edge -> STATUS at edge SYNC_STAGES+1.
// Backpressure: none; PREADY is 1 in every access phase (zero wait states).
module kth_pmod_gpio #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_BITS   = 5
) (
  input  logic        clk_in,
  input  logic        reset_int,
  input  logic [31:0] PADDR,
  input  logic        PENABLE,
  input  logic        PSEL,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        irq_en_3,
  output logic        irq_3,
  input  logic [15:0] pmod_gpi,
  output logic [15:0] pmod_gpo,
  output logic [15:0] pmod_gpio_oe
);

  localparam logic [ADDR_BITS-1:0] OFF_OUT    = ADDR_BITS'(8'h00);
  localparam logic [ADDR_BITS-1:0] OFF_OE     = ADDR_BITS'(8'h04);
  localparam logic [ADDR_BITS-1:0] OFF_IN     = ADDR_BITS'(8'h08);
  localparam logic [ADDR_BITS-1:0] OFF_RISE   = ADDR_BITS'(8'h0C);
  localparam logic [ADDR_BITS-1:0] OFF_FALL   = ADDR_BITS'(8'h10);
  localparam logic [ADDR_BITS-1:0] OFF_STATUS = ADDR_BITS'(8'h14);
  localparam logic [ADDR_BITS-1:0] OFF_TOGGLE = ADDR_BITS'(8'h18);
  // Warm-up spans the synchroniser fill plus the prev flop capture.
  localparam logic [2:0]           WARM_END   = 3'(SYNC_STAGES + 1);

  logic [15:0] r_out;
  logic [15:0] r_oe;
  logic [15:0] r_rise_en;
  logic [15:0] r_fall_en;
  logic [15:0] r_status;
  logic [15:0] r_prev;
  logic [15:0] r_sync [SYNC_STAGES];
  logic [2:0]  r_warm;

  logic                 w_access;
  logic                 w_wr;
  logic [ADDR_BITS-1:0] w_off;
  logic [15:0]          w_in;
  logic                 w_warm_done;
  logic [15:0]          w_event;
  logic [15:0]          w_w1c;
  logic [15:0]          w_rdata;
  logic                 w_unmapped;
  logic                 w_unused;

  assign w_access    = PSEL & PENABLE;
  assign w_wr        = w_access & PWRITE;
  assign w_off       = PADDR[ADDR_BITS-1:0];
  assign w_in        = r_sync[SYNC_STAGES-1];
  assign w_warm_done = (r_warm == WARM_END);
  // Upper address bits were already decoded by the interconnect; upper data bits are reserved.
  assign w_unused    = ^{PADDR[31:ADDR_BITS], PWDATA[31:16]};

  assign w_event = w_warm_done ? ((w_in & ~r_prev & r_rise_en) | (~w_in & r_prev & r_fall_en))
                               : 16'h0000;
  assign w_w1c   = (w_wr && (w_off == OFF_STATUS)) ? PWDATA[15:0] : 16'h0000;

  // Input synchroniser chain and the previous-sample flop used for edge detection.
  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 16'h0000;
      r_prev <= 16'h0000;
    end else begin
      r_sync[0] <= pmod_gpi;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_in;
    end
  end

  // Warm-up counter: saturates once the synchroniser and prev flop hold real pin data.
  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      r_warm <= 3'd0;
    end else if (!w_warm_done) begin
      r_warm <= r_warm + 3'd1;
    end
  end

  // Control registers; a write commits on the edge ending its access phase.
  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      r_out     <= 16'h0000;
      r_oe      <= 16'h0000;
      r_rise_en <= 16'h0000;
      r_fall_en <= 16'h0000;
    end else if (w_wr) begin
      case (w_off)
        OFF_OUT:    r_out     <= PWDATA[15:0];
        OFF_TOGGLE: r_out     <= r_out ^ PWDATA[15:0];
        OFF_OE:     r_oe      <= PWDATA[15:0];
        OFF_RISE:   r_rise_en <= PWDATA[15:0];
        OFF_FALL:   r_fall_en <= PWDATA[15:0];
        default:    ;
      endcase
    end
  end

  // Sticky event flags; a new event wins over a simultaneous write-one-to-clear.
  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      r_status <= 16'h0000;
    end else begin
      r_status <= (r_status & ~w_w1c) | w_event;
    end
  end

  // Read mux and unmapped-offset decode.
  always_comb begin
    w_rdata    = 16'h0000;
    w_unmapped = 1'b0;
    case (w_off)
      OFF_OUT:    w_rdata = r_out;
      OFF_OE:     w_rdata = r_oe;
      OFF_IN:     w_rdata = w_in;
      OFF_RISE:   w_rdata = r_rise_en;
      OFF_FALL:   w_rdata = r_fall_en;
      OFF_STATUS: w_rdata = r_status;
      OFF_TOGGLE: w_rdata = 16'h0000;
      default:    w_unmapped = 1'b1;
    endcase
  end

  assign PREADY       = w_access;
  assign PSLVERR      = w_access & w_unmapped;
  assign PRDATA       = (w_access && !PWRITE) ? {16'h0000, w_rdata} : 32'h0000_0000;
  assign irq_3        = irq_en_3 & (|r_status);
  assign pmod_gpo     = r_out;
  assign pmod_gpio_oe = r_oe;

endmodule

// File: doc/kth_pmod_gpio.md
# kth_pmod_gpio

APB-programmable 16-pin PMOD GPIO controller for the KTH student subsystem, and the first functional stage behind the subsystem APB port.
- Consumes APB transfers and drives `pmod_gpo` / `pmod_gpio_oe`.
- Samples `pmod_gpi` through a synchroniser and detects rising and falling edges per pin.
- Raises `irq_3` toward the SoC interrupt controller when an enabled edge occurs.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: input synchroniser depth; legal range 2–4.
- `ADDR_BITS`, default 5: number of low `PADDR` bits decoded. Higher bits are ignored; the interconnect already selected this block.

Ports:
- `clk_in` in 1: subsystem clock. Everything runs in this single clock domain.
- `reset_int` in 1: reset, asynchronous, active-low. Asserting it clears every flop immediately.
- `PADDR` in 32: APB address.
- `PENABLE` in 1: APB access phase.
- `PSEL` in 1: APB select.
- `PWDATA` in 32: APB write data.
- `PWRITE` in 1: 1 = write, 0 = read.
- `PRDATA` out 32: APB read data.
- `PREADY` out 1: APB ready.
- `PSLVERR` out 1: APB error.
- `irq_en_3` in 1: global interrupt enable from SS_Ctrl.
- `irq_3` out 1: level interrupt.
- `pmod_gpi` in 16: asynchronous pin inputs.
- `pmod_gpo` out 16: pin output values.
- `pmod_gpio_oe` out 16: per-pin output enable; 1 = drive.

## Operation
Register map (word offsets; all accesses are 32-bit; bits 31:16 read 0 and ignore writes):
- 0x00 `OUT`, RW: drives `pmod_gpo`.
- 0x04 `OE`, RW: drives `pmod_gpio_oe`.
- 0x08 `IN`, RO: synchronised pin values. Writes have no effect and no error.
- 0x0C `RISE_EN`, RW: per-pin enable for rising-edge events.
- 0x10 `FALL_EN`, RW: per-pin enable for falling-edge events.
- 0x14 `STATUS`, RW1C: sticky per-pin event flags.
- 0x18 `TOGGLE`, WO: `OUT ^= PWDATA[15:0]`. Reads return 0.
- Any other offset: `PSLVERR`=1 in the access phase. Writes are discarded; `PRDATA`=0.

Datapath:
- Synchroniser: `SYNC_STAGES` flops per pin. A `prev` flop holds the last synchronised value.
- Rising event on pin i: `sync[i] & ~prev[i] & RISE_EN[i]`. Falling event: `~sync[i] & prev[i] & FALL_EN[i]`. Either event sets `STATUS[i]`.
- Warm-up: a counter runs from reset release for `SYNC_STAGES`+1 cycles. During warm-up, event detection is suppressed. A pin already high at reset release therefore never produces a spurious rising event.
- STATUS set/clear collision: if a W1C write to bit i coincides with a new event on pin i, the set wins and the bit stays 1.
- `irq_3 = irq_en_3 & |STATUS`. This is combinational from flops. With `irq_en_3`=0, `STATUS` still accumulates.

APB behaviour:
- Zero wait states: `PREADY`=1 whenever `PSEL & PENABLE`, otherwise 0.
- `PRDATA` is valid only when `PSEL & PENABLE & ~PWRITE`; it is 0 at all other times.
- `PSLVERR` is asserted only in the access phase of an unmapped access.
- A write commits at the rising edge that ends its access phase. The setup phase has no side effects.

## Timing
Reset values:
- `PRDATA`, `PREADY`, `PSLVERR`, `irq_3`, `pmod_gpo`, `pmod_gpio_oe` = 0.
- All registers, synchroniser flops, `prev` and the warm-up counter = 0.

Latencies:
- `OUT` / `OE` / `TOGGLE` write → pin outputs change 0 cycles after the committing edge (outputs are register outputs).
- Pin change → `IN` reflects it after `SYNC_STAGES` edges.
- Pin change → `STATUS` bit set at edge `SYNC_STAGES`+1 after the change, provided warm-up has completed.
- `STATUS` set → `irq_3` high in the same cycle.
- W1C of the last set bit → `irq_3` low in the cycle after the commit edge.

Boundary conditions:
- Back-to-back APB transfers are supported with no idle cycle.
- A pin toggling every cycle sets `STATUS` once; the bit stays sticky.
- Reset asserted mid-transfer aborts the transfer: registers clear and no partial commit occurs.

## Test plan
- Reset, then read all offsets → `PRDATA`=0; `PREADY`=1 in each access phase; `PSLVERR`=0. Read offset 0x1C → `PSLVERR`=1, `PRDATA`=0.
- Write `OUT`=0xA5A5, `OE`=0x00FF, then `TOGGLE`=0xFFFF → `pmod_gpo`=0xA5A5, then 0x5A5A; `pmod_gpio_oe`=0x00FF; read-back matches.
- Hold `pmod_gpi`=0xFFFF through reset release → no `STATUS` bits set. Then drive 0x1234 → `IN`=0x1234 exactly 2 cycles later (`SYNC_STAGES`=2).
- `RISE_EN`=0x0001, `irq_en_3`=1, drive pin 0 from 0 to 1 → `STATUS`=0x0001 three edges after the change, and `irq_3`=1. Write `STATUS`=0x0001 → `irq_3`=0 on the next cycle.
- `FALL_EN`=0x8000, `irq_en_3`=0, drive pin 15 from 1 to 0 → `STATUS`=0x8000 and `irq_3`=0. Raise `irq_en_3` → `irq_3`=1 in the same cycle.
- Arrange a W1C of bit 3 on the same edge as a new rising event on pin 3 → `STATUS[3]` remains 1 and `irq_3` stays high.
